// File: rtl/bfly_out_reorder.sv
// Output reorder for a radix-2 SDF butterfly: forwards sums immediately,
// buffers differences, then replays them so each frame leaves as 2*SIZE beats.
module bfly_out_reorder #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned SIZE       = 16,
  parameter int unsigned IN_SIZE    = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         bfly_valid,
  input  logic signed [DATA_WIDTH-1:0] sum_i  [0:IN_SIZE-1],
  input  logic signed [DATA_WIDTH-1:0] sum_q  [0:IN_SIZE-1],
  input  logic signed [DATA_WIDTH-1:0] diff_i [0:IN_SIZE-1],
  input  logic signed [DATA_WIDTH-1:0] diff_q [0:IN_SIZE-1],
  output logic                         dout_valid,
  output logic signed [DATA_WIDTH-1:0] dout_i [0:IN_SIZE-1],
  output logic signed [DATA_WIDTH-1:0] dout_q [0:IN_SIZE-1],
  output logic                         dout_first,
  output logic                         dout_last,
  output logic                         busy,
  output logic                         overflow
);

  localparam int unsigned PW = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          wr_last_c, rd_last_c, wr_en_c;

  logic                         dout_valid_q, dout_valid_d;
  logic                         dout_first_q, dout_first_d;
  logic                         dout_last_q,  dout_last_d;
  logic                         busy_q,       busy_d;
  logic                         overflow_q,   overflow_d;
  logic signed [DATA_WIDTH-1:0] dout_i_q [0:IN_SIZE-1];
  logic signed [DATA_WIDTH-1:0] dout_q_q [0:IN_SIZE-1];
  logic signed [DATA_WIDTH-1:0] dout_i_d [0:IN_SIZE-1];
  logic signed [DATA_WIDTH-1:0] dout_q_d [0:IN_SIZE-1];

  // Difference store; contents are don't-care until written in PASS
  logic signed [DATA_WIDTH-1:0] store_i [0:SIZE-1][0:IN_SIZE-1];
  logic signed [DATA_WIDTH-1:0] store_q [0:SIZE-1][0:IN_SIZE-1];

  assign wr_last_c = (wr_ptr_q == PW'(SIZE - 1));
  assign rd_last_c = (rd_ptr_q == PW'(SIZE - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bfly_valid) begin
          state_d = wr_last_c ? S_DRAIN : S_PASS;
        end
      end
      S_PASS: begin
        if (bfly_valid && wr_last_c) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (rd_last_c) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next-values
  always_comb begin
    wr_en_c      = 1'b0;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    dout_valid_d = 1'b0;
    dout_first_d = 1'b0;
    dout_last_d  = 1'b0;
    overflow_d   = 1'b0;
    busy_d       = (state_d != S_IDLE);
    dout_i_d     = dout_i_q;
    dout_q_d     = dout_q_q;
    case (state_q)
      S_IDLE, S_PASS: begin
        if (bfly_valid) begin
          wr_en_c      = 1'b1;
          wr_ptr_d     = wr_last_c ? '0 : wr_ptr_q + PW'(1);
          dout_valid_d = 1'b1;
          dout_first_d = (state_q == S_IDLE);
          dout_i_d     = sum_i;
          dout_q_d     = sum_q;
        end
      end
      S_DRAIN: begin
        rd_ptr_d     = rd_last_c ? '0 : rd_ptr_q + PW'(1);
        dout_valid_d = 1'b1;
        dout_last_d  = rd_last_c;
        overflow_d   = bfly_valid;
        for (int l = 0; l < int'(IN_SIZE); l++) begin
          dout_i_d[l] = store_i[rd_ptr_q][l];
          dout_q_d[l] = store_q[rd_ptr_q][l];
        end
      end
      default: ;
    endcase
  end

  // Output and pointer registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      dout_valid_q <= 1'b0;
      dout_first_q <= 1'b0;
      dout_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      for (int l = 0; l < int'(IN_SIZE); l++) begin
        dout_i_q[l] <= '0;
        dout_q_q[l] <= '0;
      end
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      dout_valid_q <= dout_valid_d;
      dout_first_q <= dout_first_d;
      dout_last_q  <= dout_last_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
      dout_i_q     <= dout_i_d;
      dout_q_q     <= dout_q_d;
    end
  end

  // Store write port, no reset needed
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int l = 0; l < int'(IN_SIZE); l++) begin
        store_i[wr_ptr_q][l] <= diff_i[l];
        store_q[wr_ptr_q][l] <= diff_q[l];
      end
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout_first = dout_first_q;
  assign dout_last  = dout_last_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign dout_i     = dout_i_q;
  assign dout_q     = dout_q_q;

endmodule

// File: doc/bfly_out_reorder.md
Name: bfly_out_reorder

Overview:
- Output-side companion of the butterfly input delay line in each radix-2 SDF FFT stage.
- Receives a burst of SIZE butterfly results per frame; each result is a sum vector and a difference vector of IN_SIZE lanes.
- Forwards the sum vectors immediately, stores the difference vectors, then replays them. The next stage sees one contiguous 2*SIZE-beat stream per frame.

Parameters:
- DATA_WIDTH, 10, signed sample width per I/Q lane (input width + 1 for butterfly growth).
- SIZE, 16, butterfly beats per frame; also the depth of the difference store.
- IN_SIZE, 16, parallel lanes per beat.

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  synchronous active-low reset
- bfly_valid  input  1  butterfly result beat valid
- sum_i, sum_q  input  signed [DATA_WIDTH-1:0] x [0:IN_SIZE-1]  butterfly sum (a+b) lanes
- diff_i, diff_q  input  signed [DATA_WIDTH-1:0] x [0:IN_SIZE-1]  butterfly difference (a-b) lanes
- dout_valid  output  1  output beat valid
- dout_i, dout_q  output  signed [DATA_WIDTH-1:0] x [0:IN_SIZE-1]  reordered output lanes
- dout_first  output  1  1-cycle pulse with the first beat of a frame
- dout_last  output  1  1-cycle pulse with the final beat of a frame
- busy  output  1  high in PASS or DRAIN
- overflow  output  1  1-cycle pulse when an input beat is dropped

Behaviour:
- Single clock domain. Reset is synchronous and active-low, sampled on posedge clk.
- Reset state:
  - State is IDLE; write pointer, read pointer and beat count are 0.
  - All outputs are 0, including every dout lane.
  - Store contents are don't-care; the store is never read before it is written.
- All outputs are registered. Latency from an accepted bfly_valid beat to its sum on dout is 1 cycle.
- State machine:
  - IDLE: bfly_valid=1 accepts beat 0 and moves to PASS. Next cycle dout = sum, dout_valid=1, dout_first=1.
  - PASS: each cycle with bfly_valid=1:
    - diff is written to store[wr_ptr] and wr_ptr increments.
    - The sum is registered to dout with dout_valid=1 the next cycle.
  - PASS with bfly_valid=0: dout_valid=0, pointers hold, dout data holds its last value. Gaps are legal and do not abort the frame.
  - PASS exit: when the SIZE-th beat is accepted (wr_ptr == SIZE-1 with bfly_valid), wr_ptr wraps to 0 and the state moves to DRAIN.
  - DRAIN: one stored beat per cycle, unconditionally (no backpressure):
    - dout = store[rd_ptr], dout_valid=1, rd_ptr increments.
    - The first DRAIN output directly follows the last sum output with no bubble.
  - DRAIN exit: after SIZE reads, rd_ptr wraps to 0, dout_last=1 accompanies store[SIZE-1], and the state moves to IDLE.
- Input while in DRAIN, including the final DRAIN cycle:
  - The beat is dropped and not stored.
  - overflow pulses 1 cycle later, aligned with the registered outputs.
  - The drain continues undisturbed.
- Input arriving the cycle after DRAIN exit (state IDLE) is accepted normally. The minimum frame-to-frame spacing is therefore 2*SIZE cycles of input.
- Output order per frame: sum[0..SIZE-1], then diff[0..SIZE-1]. The I and Q lane mapping is preserved lane-for-lane.
- Width: data is passed through unmodified. No rounding, scaling or saturation.
- dout_first and dout_last are never high in the same cycle when SIZE>=1, since a frame spans 2*SIZE beats.
- busy is 1 in PASS and DRAIN, 0 in IDLE. It is registered and aligned with the state register.
- Reset asserted mid-PASS or mid-DRAIN:
  - The next cycle the block is in IDLE with all outputs 0.
  - The partial frame is discarded, with no dout_last.
- Pointers are $clog2(SIZE) bits, or 1 bit when SIZE=1. SIZE need not be a power of 2; wraps are by explicit compare.

Test Plan:
- Reset/idle: hold rstn=0 for 3 cycles with bfly_valid=1 -> dout_valid, busy, overflow and all dout lanes stay 0. The first valid beat after release produces dout_first one cycle later.
- Basic frame: 16 consecutive beats, sum lane j = 16*k+j and diff lane j = -(16*k+j) for beat k -> 32 consecutive dout_valid cycles:
  - beats 0-15 carry the sums; beats 16-31 carry the diffs in order k=0..15.
  - dout_first on cycle 1; dout_last on cycle 32.
- Gapped input: bfly_valid alternates 1/0 across 16 beats -> sums appear with matching 1-cycle gaps. The drain starts the cycle after the 16th sum and runs 16 contiguous cycles.
- Overflow: assert bfly_valid on drain cycles 3 and 16 -> overflow pulses twice, drained diff values are unchanged, and the block returns to IDLE after dout_last.
- Back-to-back frames: the second frame starts the cycle after DRAIN exit -> its sums follow dout_last with no overlap, and frame-2 diffs are not corrupted by frame-1 data.
- Mid-frame reset: rstn=0 during drain beat 5 -> all outputs 0 next cycle. A fresh frame after release reproduces the basic-frame output exactly.
